// File: rtl/mem_port_arbiter_2to1.sv
// Two-port arbiter/sequencer for the shared 16-bit memory port; holds the grant for a whole access.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN to make port 1 win every tie.
module mem_port_arbiter_2to1 (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  // One-hot busy encoding so each grant is a direct register bit.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   tie_pick1;

`ifdef ARB_FIXED_PRIORITY_EN
  assign tie_pick1 = 1'b1;
`else
  logic last_q, last_d;
  assign tie_pick1 = ~last_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  // On completion only the other port is considered, which forbids an immediate re-grant.
  always_comb begin
    state_d = state_q;
`ifndef ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = tie_pick1 ? BUSY1 : BUSY0;
        else if (req0)     state_d = BUSY0;
        else if (req1)     state_d = BUSY1;
      end
      BUSY0: begin
        if (mem_ready) begin
          state_d = req1 ? BUSY1 : IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
          last_d  = 1'b0;
`endif
        end
      end
      BUSY1: begin
        if (mem_ready) begin
          state_d = req0 ? BUSY0 : IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
          last_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0 = state_q[0];
  assign gnt1 = state_q[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state_q)
      BUSY0: begin
        mem_en    = 1'b1;
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        done0     = mem_ready;
      end
      BUSY1: begin
        mem_en    = 1'b1;
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        done1     = mem_ready;
      end
      default: ;
    endcase
    rdata = (done0 || done1) ? mem_rdata : 16'h0000;
  end

endmodule

// File: tb/tb_mem_port_arbiter_2to1.sv
// Bench for mem_port_arbiter_2to1: directed scenarios, then randomized traffic against an owner/last model.
module tb_mem_port_arbiter_2to1;
  logic        clk = 1'b0;
  logic        rst, req0, req1, we0, we1, mem_ready;
  logic [15:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic        gnt0, gnt1, done0, done1, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;

  int total  = 0;
  int passed = 0;
  int m_owner = -1;   // port currently holding the memory, -1 when idle
  bit m_last  = 1'b1;
  bit e_done0, e_done1;
  bit pend0, pend1;
  int first_port;

`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Check all outputs against the model for the current cycle, then advance the model across the edge.
  task automatic cycle();
    logic [15:0] a, w;
    logic        wen;
    logic [1:0]  rq;
    int          other;
    #1;
    a = 16'h0000; w = 16'h0000; wen = 1'b0;
    if (m_owner == 0) begin a = addr0; w = wdata0; wen = we0; end
    else if (m_owner == 1) begin a = addr1; w = wdata1; wen = we1; end
    e_done0 = (m_owner == 0) && mem_ready;
    e_done1 = (m_owner == 1) && mem_ready;
    chk("gnt0",      gnt0,      m_owner == 0);
    chk("gnt1",      gnt1,      m_owner == 1);
    chk("onehot",    gnt0 & gnt1, 1'b0);
    chk("mem_en",    mem_en,    m_owner >= 0);
    chk("mem_we",    mem_we,    wen);
    chk("mem_addr",  mem_addr,  a);
    chk("mem_wdata", mem_wdata, w);
    chk("done0",     done0,     e_done0);
    chk("done1",     done1,     e_done1);
    chk("rdata",     rdata,     (e_done0 || e_done1) ? mem_rdata : 16'h0000);
    rq = {req1, req0};
    if (rst) begin
      m_owner = -1;
      m_last  = 1'b1;
    end else if (m_owner < 0) begin
      if (rq == 2'b11)  m_owner = FIXED ? 1 : (m_last ? 0 : 1);
      else if (rq[0])   m_owner = 0;
      else if (rq[1])   m_owner = 1;
    end else if (mem_ready) begin
      m_last  = (m_owner == 1);
      other   = 1 - m_owner;
      m_owner = rq[other] ? other : -1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    @(posedge clk);
    #1;

    // Reset held two cycles with both requests high
    cycle();
    cycle();
    chk("rst_gnt0",   gnt0,     1'b0);
    chk("rst_gnt1",   gnt1,     1'b0);
    chk("rst_mem_en", mem_en,   1'b0);
    chk("rst_addr",   mem_addr, 16'h0000);

    // Contention: 1-cycle accesses alternate with no idle gap
    rst = 1'b0;
    cycle();
    first_port = FIXED ? 1 : 0;
    mem_ready = 1'b1;
    mem_rdata = 16'hC0DE;
    for (int i = 0; i < 4; i++) begin
      chk("order_gnt0", gnt0, ((first_port ^ (i & 1)) == 0));
      chk("order_gnt1", gnt1, ((first_port ^ (i & 1)) == 1));
      chk("order_en",   mem_en, 1'b1);
      cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    cycle();
    mem_ready = 1'b0;
    cycle();

    // Single read of 3 busy cycles
    req0 = 1'b1; addr0 = 16'h0040; we0 = 1'b0;
    cycle();
    chk("rd_gnt0", gnt0, 1'b1);
    chk("rd_addr", mem_addr, 16'h0040);
    cycle();
    chk("rd_gnt0_2", gnt0, 1'b1);
    cycle();
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("rd_done0", done0, 1'b1);
    chk("rd_rdata", rdata, 16'hBEEF);
    cycle();
    req0 = 1'b0; mem_ready = 1'b0;
    chk("rd_release", gnt0, 1'b0);
    cycle();

    // Write through port 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h1234; wdata1 = 16'h5A5A;
    cycle();
    chk("wr_gnt1",  gnt1,      1'b1);
    chk("wr_we",    mem_we,    1'b1);
    chk("wr_addr",  mem_addr,  16'h1234);
    chk("wr_wdata", mem_wdata, 16'h5A5A);
    mem_ready = 1'b1;
    #1;
    chk("wr_done1", done1, 1'b1);
    cycle();
    req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
    cycle();

    // Reset in the second busy cycle aborts without a done
    req0 = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("abort_nodone", done0, 1'b0);
    cycle();
    chk("abort_gnt0",   gnt0,   1'b0);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_done0",  done0,  1'b0);
    rst = 1'b0; req0 = 1'b0;
    cycle();

    // Randomized traffic
    pend0 = 1'b0; pend1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend0 && $urandom_range(0, 3) == 0) begin
        pend0 = 1'b1; addr0 = 16'($urandom); wdata0 = 16'($urandom); we0 = 1'($urandom_range(0, 1));
      end
      if (!pend1 && $urandom_range(0, 3) == 0) begin
        pend1 = 1'b1; addr1 = 16'($urandom); wdata1 = 16'($urandom); we1 = 1'($urandom_range(0, 1));
      end
      req0 = pend0; req1 = pend1;
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      if (e_done0) pend0 = 1'b0;
      if (e_done1) pend1 = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
